demosaic_seq_ctrl: RTL and testbench

Frame/line sequencer that sits in front of the ISP demosaic datapath. It accepts the Bayer pixel stream and tracks the row/column position and Bayer phase of every pixel. It also generates border flags and gates the datapath output while the first line primes the line buffers. After the last input line it injects one flush line so the final output line is produced.

---
 rtl/demosaic_seq_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_demosaic_seq_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/demosaic_seq_ctrl.sv
// Frame/line sequencer ahead of the demosaic datapath: tracks Bayer position,
// border flags and priming, and appends one flush line per frame.
module demosaic_seq_ctrl #(
  parameter int MAX_WIDTH = 4096,
  parameter int CNT_W     = 13
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             cfg_enable_i,
  input  logic [CNT_W-1:0] cfg_width_i,
  input  logic [CNT_W-1:0] cfg_height_i,
  input  logic [1:0]       cfg_phase_i,
  input  logic             s_valid_i,
  output logic             s_ready_o,
  input  logic             s_sof_i,
  input  logic [23:0]      s_data_i,
  output logic             dm_valid_o,
  output logic [23:0]      dm_data_o,
  output logic [CNT_W-1:0] dm_col_o,
  output logic [CNT_W-1:0] dm_row_o,
  output logic [1:0]       dm_phase_o,
  output logic [3:0]       dm_border_o,
  output logic             dm_out_en_o,
  input  logic             m_ready_i,
  output logic             busy_o,
  output logic             frame_done_o,
  output logic             err_sof_o,
  output logic             cfg_err_o
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] PRIME = 3'd1;
  localparam logic [2:0] RUN   = 3'd2;
  localparam logic [2:0] FLUSH = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] MIN_W = CNT_W'(4);
  localparam logic [CNT_W-1:0] MAX_W = CNT_W'(MAX_WIDTH);
  localparam logic [CNT_W-1:0] MIN_H = CNT_W'(3);

  logic [2:0]       state;
  logic [CNT_W-1:0] col, row, width, height;
  logic [1:0]       phase;

  logic             xfer, cfg_ok, last_col;
  logic             beat_v, beat_en;
  logic [23:0]      beat_data;
  logic [CNT_W-1:0] beat_col, beat_row;
  logic [1:0]       beat_phase;
  logic [3:0]       beat_border;

  assign s_ready_o = ~rst_i & m_ready_i & ((state == IDLE) | (state == PRIME) | (state == RUN));
  assign xfer      = s_valid_i & s_ready_o;
  assign cfg_ok    = (cfg_width_i >= MIN_W) && (cfg_width_i <= MAX_W) && (cfg_height_i >= MIN_H);
  assign last_col  = (col == width - ONE);
  assign busy_o    = (state != IDLE);

  // Beat to be registered onto the dm_* outputs this cycle.
  always_comb begin
    beat_v      = 1'b0;
    beat_data   = s_data_i;
    beat_col    = col;
    beat_row    = row;
    beat_phase  = phase ^ {row[0], col[0]};
    beat_border = '0;
    beat_en     = 1'b1;
    case (state)
      IDLE: begin
        if (xfer && (!cfg_enable_i || (s_sof_i && cfg_ok))) begin
          beat_v     = 1'b1;
          beat_col   = '0;
          beat_row   = '0;
          beat_phase = cfg_phase_i;
          beat_en    = ~cfg_enable_i;
        end
      end
      PRIME, RUN: begin
        if (xfer) begin
          if (s_sof_i) begin
            beat_v     = cfg_ok;
            beat_col   = '0;
            beat_row   = '0;
            beat_phase = cfg_phase_i;
            beat_en    = 1'b0;
          end else begin
            beat_v  = 1'b1;
            beat_en = (state == RUN);
            if (state == RUN)
              beat_border = {row == ONE, row == height, col == '0, last_col};
          end
        end
      end
      FLUSH: begin
        if (m_ready_i) begin
          beat_v      = 1'b1;
          beat_data   = '0;
          beat_border = {row == ONE, row == height, col == '0, last_col};
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= IDLE;
      col          <= '0;
      row          <= '0;
      width        <= '0;
      height       <= '0;
      phase        <= '0;
      dm_valid_o   <= 1'b0;
      dm_data_o    <= '0;
      dm_col_o     <= '0;
      dm_row_o     <= '0;
      dm_phase_o   <= '0;
      dm_border_o  <= '0;
      dm_out_en_o  <= 1'b0;
      frame_done_o <= 1'b0;
      err_sof_o    <= 1'b0;
      cfg_err_o    <= 1'b0;
    end else begin
      dm_valid_o   <= beat_v;
      frame_done_o <= 1'b0;
      err_sof_o    <= 1'b0;
      cfg_err_o    <= 1'b0;
      if (beat_v) begin
        dm_data_o   <= beat_data;
        dm_col_o    <= beat_col;
        dm_row_o    <= beat_row;
        dm_phase_o  <= beat_phase;
        dm_border_o <= beat_border;
        dm_out_en_o <= beat_en;
      end
      case (state)
        IDLE: begin
          if (xfer && cfg_enable_i && s_sof_i) begin
            if (cfg_ok) begin
              width  <= cfg_width_i;
              height <= cfg_height_i;
              phase  <= cfg_phase_i;
              col    <= ONE;
              row    <= '0;
              state  <= PRIME;
            end else begin
              cfg_err_o <= 1'b1;
            end
          end
        end
        PRIME, RUN: begin
          if (xfer) begin
            if (s_sof_i) begin
              // Mid-frame SOF restarts the frame with this beat as (0,0).
              if (cfg_ok) begin
                err_sof_o <= 1'b1;
                width     <= cfg_width_i;
                height    <= cfg_height_i;
                phase     <= cfg_phase_i;
                col       <= ONE;
                row       <= '0;
                state     <= PRIME;
              end else begin
                cfg_err_o <= 1'b1;
                col       <= '0;
                row       <= '0;
                state     <= IDLE;
              end
            end else if (last_col) begin
              col <= '0;
              row <= row + ONE;
              if (state == PRIME)
                state <= RUN;
              else if (row == height - ONE)
                state <= FLUSH;
            end else begin
              col <= col + ONE;
            end
          end
        end
        FLUSH: begin
          if (m_ready_i) begin
            if (last_col) begin
              col          <= '0;
              frame_done_o <= 1'b1;
              state        <= DONE;
            end else begin
              col <= col + ONE;
            end
          end
        end
        DONE: begin
          row   <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_demosaic_seq_ctrl.sv
// Directed bench for demosaic_seq_ctrl using a 4x3 frame; a monitor logs
// every dm beat and pulse so the main sequence can check them afterwards.
module tb_demosaic_seq_ctrl;

  typedef struct packed {
    logic [23:0] data;
    logic [12:0] col;
    logic [12:0] row;
    logic [1:0]  ph;
    logic [3:0]  bd;
    logic        en;
  } beat_t;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        cfg_enable_i;
  logic [12:0] cfg_width_i, cfg_height_i;
  logic [1:0]  cfg_phase_i;
  logic        s_valid_i, s_ready_o, s_sof_i;
  logic [23:0] s_data_i;
  logic        dm_valid_o;
  logic [23:0] dm_data_o;
  logic [12:0] dm_col_o, dm_row_o;
  logic [1:0]  dm_phase_o;
  logic [3:0]  dm_border_o;
  logic        dm_out_en_o, m_ready_i, busy_o, frame_done_o, err_sof_o, cfg_err_o;

  int passed = 0;
  int checks = 0;
  int fails  = 0;

  beat_t q[$];
  int    fd_cnt = 0, fd_at = 0, esof_cnt = 0, cerr_cnt = 0;

  always #5 clk_i = ~clk_i;

  demosaic_seq_ctrl #(.MAX_WIDTH(4096), .CNT_W(13)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .cfg_enable_i(cfg_enable_i),
    .cfg_width_i(cfg_width_i), .cfg_height_i(cfg_height_i), .cfg_phase_i(cfg_phase_i),
    .s_valid_i(s_valid_i), .s_ready_o(s_ready_o), .s_sof_i(s_sof_i), .s_data_i(s_data_i),
    .dm_valid_o(dm_valid_o), .dm_data_o(dm_data_o), .dm_col_o(dm_col_o), .dm_row_o(dm_row_o),
    .dm_phase_o(dm_phase_o), .dm_border_o(dm_border_o), .dm_out_en_o(dm_out_en_o),
    .m_ready_i(m_ready_i), .busy_o(busy_o), .frame_done_o(frame_done_o),
    .err_sof_o(err_sof_o), .cfg_err_o(cfg_err_o)
  );

  always @(negedge clk_i) begin
    if (dm_valid_o) q.push_back({dm_data_o, dm_col_o, dm_row_o, dm_phase_o, dm_border_o, dm_out_en_o});
    if (frame_done_o) begin
      fd_cnt = fd_cnt + 1;
      fd_at  = q.size();
    end
    if (err_sof_o) esof_cnt = esof_cnt + 1;
    if (cfg_err_o) cerr_cnt = cerr_cnt + 1;
  end

  function automatic logic [23:0] pix(input int r, input int c);
    return {8'hA5, 8'(r), 8'(c)};
  endfunction

  // Expected beat i of a 4x3 frame; row 3 is the flush line.
  function automatic beat_t exp_beat(input int i, input logic [1:0] ph);
    beat_t b;
    int r, c;
    r      = i / 4;
    c      = i % 4;
    b.data = (r == 3) ? 24'h0 : pix(r, c);
    b.col  = 13'(c);
    b.row  = 13'(r);
    b.ph   = ph ^ {r[0], c[0]};
    b.bd   = (r == 0) ? 4'b0000 : {r == 1, r == 3, c == 0, c == 3};
    b.en   = (r != 0);
    return b;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic px(input logic sof, input logic [23:0] d);
    int n;
    n = 0;
    s_valid_i = 1'b1;
    s_sof_i   = sof;
    s_data_i  = d;
    #1;
    while (!s_ready_o && n < 50) begin
      @(posedge clk_i); #2;
      n++;
    end
    chk("px_ready", 64'(s_ready_o), 64'd1);
    @(posedge clk_i); #1;
    s_valid_i = 1'b0;
    s_sof_i   = 1'b0;
  endtask

  task automatic send_range(input int from, input int to, input logic sof_first);
    for (int i = from; i <= to; i++)
      px(sof_first && (i == from), pix(i / 4, i % 4));
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy_o && n < 100) begin
      @(posedge clk_i); #1;
      n++;
    end
    chk(tag, 64'(busy_o), 64'd0);
    @(negedge clk_i); #1;
  endtask

  task automatic check_beats(input string tag, input int base, input int first, input int n,
                             input logic [1:0] ph);
    for (int k = 0; k < n; k++) begin
      if (base + k < q.size())
        chk($sformatf("%s_beat%0d", tag, k), 64'(q[base+k]), 64'(exp_beat(first + k, ph)));
      else
        chk($sformatf("%s_missing%0d", tag, k), 64'(q.size()), 64'(base + n));
    end
  endtask

  initial begin
    int base, fd0, es0, ce0;
    rst_i = 1'b1; cfg_enable_i = 1'b1; cfg_width_i = 13'd4; cfg_height_i = 13'd3;
    cfg_phase_i = 2'b00; s_valid_i = 1'b0; s_sof_i = 1'b0; s_data_i = '0; m_ready_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_outs", 64'({dm_valid_o, dm_data_o, dm_col_o, dm_row_o, dm_phase_o, dm_border_o,
                         dm_out_en_o, busy_o, frame_done_o, err_sof_o, cfg_err_o, s_ready_o}), 64'd0);
    rst_i = 1'b0;
    #1;
    chk("idle_ready", 64'(s_ready_o), 64'd1);

    // 1: nominal 4x3 frame
    base = q.size(); fd0 = fd_cnt;
    send_range(0, 11, 1'b1);
    wait_idle("t1_idle");
    chk("t1_count", 64'(q.size() - base), 64'd16);
    check_beats("t1", base, 0, 16, 2'b00);
    chk("t1_done_cnt", 64'(fd_cnt - fd0), 64'd1);
    chk("t1_done_align", 64'(fd_at - base), 64'd16);

    // 2: consumer stall at (1,2)
    base = q.size(); fd0 = fd_cnt;
    send_range(0, 5, 1'b1);
    s_valid_i = 1'b1; s_data_i = pix(1, 2); m_ready_i = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("t2_stall_ready%0d", k), 64'(s_ready_o), 64'd0);
      @(posedge clk_i); #1;
      chk($sformatf("t2_stall_valid%0d", k), 64'(dm_valid_o), 64'd0);
    end
    m_ready_i = 1'b1;
    send_range(6, 11, 1'b0);
    wait_idle("t2_idle");
    chk("t2_count", 64'(q.size() - base), 64'd16);
    check_beats("t2", base, 0, 16, 2'b00);
    chk("t2_done_cnt", 64'(fd_cnt - fd0), 64'd1);

    // 3: SOF mid-frame at (1,2) restarts the frame
    base = q.size(); fd0 = fd_cnt; es0 = esof_cnt;
    send_range(0, 5, 1'b1);
    px(1'b1, pix(0, 0));
    send_range(1, 11, 1'b0);
    wait_idle("t3_idle");
    chk("t3_count", 64'(q.size() - base), 64'd22);
    check_beats("t3_pre", base, 0, 6, 2'b00);
    check_beats("t3_new", base + 6, 0, 16, 2'b00);
    chk("t3_err_sof", 64'(esof_cnt - es0), 64'd1);
    chk("t3_done_cnt", 64'(fd_cnt - fd0), 64'd1);

    // 4: illegal width at SOF
    base = q.size(); ce0 = cerr_cnt; cfg_width_i = 13'd2;
    px(1'b1, 24'h111111);
    repeat (3) @(posedge clk_i);
    #1;
    chk("t4_cfg_err", 64'(cerr_cnt - ce0), 64'd1);
    chk("t4_no_beat", 64'(q.size() - base), 64'd0);
    chk("t4_busy", 64'(busy_o), 64'd0);
    chk("t4_ready", 64'(s_ready_o), 64'd1);
    cfg_width_i = 13'd4;

    // 5: phase 11
    base = q.size(); cfg_phase_i = 2'b11;
    send_range(0, 11, 1'b1);
    wait_idle("t5_idle");
    check_beats("t5", base, 0, 16, 2'b11);
    chk("t5_ph00", 64'(q[base].ph), 64'(2'b11));
    chk("t5_ph01", 64'(q[base+1].ph), 64'(2'b10));
    chk("t5_ph10", 64'(q[base+4].ph), 64'(2'b01));
    chk("t5_bd10", 64'(q[base+4].bd), 64'(4'b1010));
    chk("t5_bd23", 64'(q[base+11].bd), 64'(4'b0001));
    cfg_phase_i = 2'b00;

    // 6: reset during RUN at (2,1)
    fd0 = fd_cnt;
    send_range(0, 8, 1'b1);
    s_valid_i = 1'b1; s_data_i = pix(2, 1);
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    chk("t6_rst_outs", 64'({dm_valid_o, dm_data_o, dm_col_o, dm_row_o, dm_phase_o, dm_border_o,
                            dm_out_en_o, busy_o, frame_done_o, err_sof_o, cfg_err_o}), 64'd0);
    rst_i = 1'b0; s_valid_i = 1'b0;
    @(posedge clk_i); #1;
    @(negedge clk_i); #1;
    chk("t6_no_done", 64'(fd_cnt - fd0), 64'd0);
    base = q.size();
    send_range(0, 11, 1'b1);
    wait_idle("t6_idle");
    chk("t6_count", 64'(q.size() - base), 64'd16);
    check_beats("t6", base, 0, 16, 2'b00);
    chk("t6_done_cnt", 64'(fd_cnt - fd0), 64'd1);

    // Bypass forwards with zero position and the live phase
    base = q.size(); cfg_enable_i = 1'b0; cfg_phase_i = 2'b10;
    px(1'b0, 24'h123456);
    @(negedge clk_i); #1;
    chk("byp_count", 64'(q.size() - base), 64'd1);
    chk("byp_beat", 64'(q[base]), 64'({24'h123456, 13'd0, 13'd0, 2'b10, 4'b0000, 1'b1}));
    chk("byp_busy", 64'(busy_o), 64'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
